// File: rtl/down_sampling_pkg.sv
// Shared definitions for the 2x2 max-pooling down-sampler.
//   smax      : signed max at MAX_W bits; callers sign-extend into it and
//               truncate back, so any DATA_WIDTH <= MAX_W works unchanged.
//   OUT_LEN   : output pixels per line for the default geometry.
//   LB_DEPTH  : line-buffer entries for the default geometry.
//   lb_depth / idx_w : the same quantities for an arbitrary instance.
//   mark_t    : output marker bundle {sop, eop, sof, eof}.
package down_sampling_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_STRING_LEN  = 224;
    localparam int DEF_CHANNEL_NUM = 3;

    localparam int OUT_LEN  = DEF_STRING_LEN / 2;
    localparam int LB_DEPTH = DEF_CHANNEL_NUM * DEF_STRING_LEN / 2;
    localparam int MAX_W    = 32;

    typedef struct packed {
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } mark_t;

    function automatic logic signed [MAX_W-1:0] smax(input logic signed [MAX_W-1:0] a,
                                                     input logic signed [MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic int lb_depth(input int len, input int ch);
        return ch * (len / 2);
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/down_sampling_pool_line_buf.sv
// pool_line_buf: simple dual-port RAM holding the horizontally pooled even row.
//   clk              : write and read clock
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request; rd_data updates one cycle later and
//                      holds its value until the next read request.
// Deep buffers go to block RAM, shallow ones stay in fabric registers.
module pool_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 336,
    parameter int AW         = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    if (DEPTH >= 32) begin : g_bram
        (* ramstyle = "M10K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end else begin : g_regs
        (* ramstyle = "logic" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/down_sampling.sv
// down_sampling: 2x2 stride-2 per-channel max pooling on a channel-interleaved
// signed pixel stream, fixed 2-cycle latency, no backpressure.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   data_i, valid_i              : input sample and qualifier
//   sop_i/eop_i, sof_i/eof_i     : input line / frame markers
//   data_o, data_valid_o         : pooled sample and qualifier
//   sop_o/eop_o, sof_o/eof_o     : output line / frame markers
// Even rows: horizontal max per channel goes into the line buffer.
// Odd rows: horizontal max is combined with the stored value and emitted.
module down_sampling
    import down_sampling_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int STRING_LEN  = 224,
    parameter int CHANNEL_NUM = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         valid_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         sof_i,
    input  logic                         eof_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o
);

    localparam int DEPTH  = lb_depth(STRING_LEN, CHANNEL_NUM);
    localparam int AW     = idx_w(DEPTH);
    localparam int CW     = idx_w(CHANNEL_NUM);
    localparam int LW     = idx_w(STRING_LEN);
    localparam int STAGES = 2;

    // Line end is implied by the column counter; eop_i carries no extra info.
    logic unused_eop;
    assign unused_eop = eop_i;

    logic [CW-1:0] chan_cnt;
    logic [LW-1:0] col_cnt;
    logic          row_par;
    logic          armed;
    logic          first_pend;   // next output is the first of the frame
    logic          eof_seen;     // eof_i seen earlier on the current odd row

    logic signed [DATA_WIDTH-1:0] hold    [CHANNEL_NUM];
    logic signed [DATA_WIDTH-1:0] lb_hold [CHANNEL_NUM];
    logic signed [DATA_WIDTH-1:0] lb_rdata;
    logic                         rd_pend;
    logic [CW-1:0]                rd_ch;

    // Position of the current sample after sop/sof resync.
    logic          take, fire, rd_en, wr_en;
    logic [CW-1:0] c_ch;
    logic [LW-1:0] c_col;
    logic          c_row, col_odd, last_ch, last_col;
    logic [AW-1:0] addr;
    logic signed [DATA_WIDTH-1:0] hmax, lb_val, res;
    mark_t         mk;

    logic [STAGES:1]              vld_pipe;
    logic signed [DATA_WIDTH-1:0] s1_data;
    mark_t                        s1_mk, out_mk;

    always_comb begin
        take     = valid_i & (armed | sof_i);
        c_ch     = (sop_i | sof_i) ? '0 : chan_cnt;
        c_col    = (sop_i | sof_i) ? '0 : col_cnt;
        c_row    = sof_i ? 1'b0 : row_par;
        col_odd  = c_col[0];
        last_ch  = (c_ch == CW'(CHANNEL_NUM - 1));
        last_col = (c_col == LW'(STRING_LEN - 1));
        addr     = AW'(c_col >> 1) * AW'(CHANNEL_NUM) + AW'(c_ch);

        rd_en = take & ~col_odd & c_row;
        wr_en = take & col_odd & ~c_row;
        fire  = take & col_odd & c_row;

        hmax = DATA_WIDTH'(smax(MAX_W'(hold[c_ch]), MAX_W'(data_i)));
        // With one channel the pending read belongs to this very sample and
        // has not been copied into lb_hold yet, so forward it.
        lb_val = (rd_pend && rd_ch == c_ch) ? lb_rdata : lb_hold[c_ch];
        res    = DATA_WIDTH'(smax(MAX_W'(lb_val), MAX_W'(hmax)));

        mk.sop = (c_col == LW'(1)) && (c_ch == '0);
        mk.eop = last_col & last_ch;
        mk.sof = first_pend;
        mk.eof = last_col & last_ch & (eof_seen | eof_i);
    end

    pool_line_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_line_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(addr),
        .wr_data(hmax),
        .rd_en  (rd_en),
        .rd_addr(addr),
        .rd_data(lb_rdata)
    );

    // Sample storage needs no reset: every entry is written before use.
    always_ff @(posedge clk) begin
        if (take && !col_odd) hold[c_ch] <= data_i;
        if (take && rd_pend)  lb_hold[rd_ch] <= lb_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_cnt   <= '0;
            col_cnt    <= '0;
            row_par    <= 1'b0;
            armed      <= 1'b0;
            first_pend <= 1'b0;
            eof_seen   <= 1'b0;
            rd_pend    <= 1'b0;
            rd_ch      <= '0;
        end else if (take) begin
            if (last_ch) begin
                chan_cnt <= '0;
                col_cnt  <= last_col ? '0 : c_col + LW'(1);
                row_par  <= (last_col) ? ~c_row : c_row;
            end else begin
                chan_cnt <= c_ch + CW'(1);
                col_cnt  <= c_col;
                row_par  <= c_row;
            end

            rd_pend <= rd_en;
            rd_ch   <= c_ch;

            // eof on an even row means an odd line count: drop the frame tail.
            if (sof_i)                armed <= 1'b1;
            else if (eof_i && !c_row) armed <= 1'b0;

            if (sof_i)     first_pend <= 1'b1;
            else if (fire) first_pend <= 1'b0;

            if (fire && mk.eop) eof_seen <= 1'b0;
            else if (eof_i)     eof_seen <= c_row;
            else if (sof_i)     eof_seen <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_mk    <= '0;
            data_o   <= '0;
            out_mk   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], fire};
            s1_data  <= res;
            s1_mk    <= fire ? mk : '0;
            data_o   <= s1_data;
            out_mk   <= s1_mk;
        end
    end

    assign data_valid_o = vld_pipe[STAGES];
    assign sop_o        = out_mk.sop;
    assign eop_o        = out_mk.eop;
    assign sof_o        = out_mk.sof;
    assign eof_o        = out_mk.eof;

endmodule

// File: tb/tb_down_sampling.sv
module tb_down_sampling;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic signed [7:0] din [3];
    logic vin [3], sopi [3], eopi [3], sofi [3], eofi [3];
    logic signed [7:0] dout [3];
    logic dvo [3], sopo [3], eopo [3], sofo [3], eofo [3];

    // a: CH=1 LEN=4, b: CH=1 LEN=2, c: CH=3 LEN=2
    down_sampling #(.DATA_WIDTH(8), .STRING_LEN(4), .CHANNEL_NUM(1)) u_a (
        .clk(clk), .reset_n(reset_n), .data_i(din[0]), .valid_i(vin[0]),
        .sop_i(sopi[0]), .eop_i(eopi[0]), .sof_i(sofi[0]), .eof_i(eofi[0]),
        .data_o(dout[0]), .data_valid_o(dvo[0]), .sop_o(sopo[0]), .eop_o(eopo[0]),
        .sof_o(sofo[0]), .eof_o(eofo[0]));

    down_sampling #(.DATA_WIDTH(8), .STRING_LEN(2), .CHANNEL_NUM(1)) u_b (
        .clk(clk), .reset_n(reset_n), .data_i(din[1]), .valid_i(vin[1]),
        .sop_i(sopi[1]), .eop_i(eopi[1]), .sof_i(sofi[1]), .eof_i(eofi[1]),
        .data_o(dout[1]), .data_valid_o(dvo[1]), .sop_o(sopo[1]), .eop_o(eopo[1]),
        .sof_o(sofo[1]), .eof_o(eofo[1]));

    down_sampling #(.DATA_WIDTH(8), .STRING_LEN(2), .CHANNEL_NUM(3)) u_c (
        .clk(clk), .reset_n(reset_n), .data_i(din[2]), .valid_i(vin[2]),
        .sop_i(sopi[2]), .eop_i(eopi[2]), .sof_i(sofi[2]), .eof_i(eofi[2]),
        .data_o(dout[2]), .data_valid_o(dvo[2]), .sop_o(sopo[2]), .eop_o(eopo[2]),
        .sof_o(sofo[2]), .eof_o(eofo[2]));

    typedef struct {
        int         d;
        logic [3:0] mk;    // {sop, eop, sof, eof}
        int         cyc;
    } exp_t;

    exp_t       q   [3][$];
    int         got [3][$];
    logic [3:0] gmk [3][$];
    exp_t       ce;
    int         fr [64];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Model: every odd-row odd-column sample completes one 2x2 window; its
    // expected result is the max of the four frame samples, due 2 cycles on.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dvo[i]) begin
                got[i].push_back(int'(dout[i]));
                gmk[i].push_back({sopo[i], eopo[i], sofo[i], eofo[i]});
                if (q[i].size() == 0) begin
                    chk($sformatf("unexpected_out_%0d", i), 1, 0);
                end else begin
                    ce = q[i].pop_front();
                    chk($sformatf("data_%0d", i), int'(dout[i]), ce.d);
                    chk($sformatf("markers_%0d", i), int'({sopo[i], eopo[i], sofo[i], eofo[i]}), int'(ce.mk));
                    chk($sformatf("latency_%0d", i), cyc, ce.cyc);
                end
            end else begin
                chk($sformatf("idle_markers_%0d", i), int'({sopo[i], eopo[i], sofo[i], eofo[i]}), 0);
                if (q[i].size() > 0 && q[i][0].cyc < cyc) begin
                    ce = q[i].pop_front();
                    chk($sformatf("missing_out_%0d", i), 0, 1);
                end
            end
        end
    end

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; vin[i] = 0; sopi[i] = 0; eopi[i] = 0; sofi[i] = 0; eofi[i] = 0;
        end
    endtask

    task automatic drive(input int inst, input int r0, input int r1, input int len,
                         input int ch, input bit sof_en, input bit eof_en,
                         input bit exp_en, input int gap);
        bit   first;
        int   idx, rs;
        exp_t e;
        first = sof_en;
        rs    = len * ch;
        for (int r = r0; r < r1; r++)
            for (int col = 0; col < len; col++)
                for (int k = 0; k < ch; k++) begin
                    while (gap > 0 && $urandom_range(99) < gap) begin
                        vin[inst] = 0; sopi[inst] = 0; eopi[inst] = 0;
                        sofi[inst] = 0; eofi[inst] = 0;
                        @(posedge clk); #1;
                    end
                    idx        = r * rs + col * ch + k;
                    din[inst]  = 8'(fr[idx]);
                    vin[inst]  = 1;
                    sopi[inst] = (col == 0 && k == 0);
                    eopi[inst] = (col == len - 1 && k == ch - 1);
                    sofi[inst] = sof_en && r == r0 && col == 0 && k == 0;
                    eofi[inst] = eof_en && r == r1 - 1 && col == len - 1 && k == ch - 1;
                    if (exp_en && (r % 2) == 1 && (col % 2) == 1) begin
                        e.d   = max2(max2(fr[idx], fr[idx - ch]),
                                     max2(fr[idx - rs], fr[idx - rs - ch]));
                        e.mk  = {(col == 1 && k == 0), (col == len - 1 && k == ch - 1),
                                 first, eofi[inst]};
                        e.cyc = cyc + 2;
                        first = 0;
                        q[inst].push_back(e);
                    end
                    @(posedge clk); #1;
                end
        idle_all();
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("queue_empty_%0d", i), q[i].size(), 0);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            got[i].delete();
            gmk[i].delete();
        end
    endtask

    task automatic fill_a();
        for (int i = 0; i < 16; i++) fr[i] = i + 1;
    endtask

    // Hand-computed pooled result of the 4x4 ramp frame, starting at log slot off.
    task automatic pin_a(input int off);
        int         ea [4];
        logic [3:0] em [4];
        ea = '{6, 8, 14, 16};
        em = '{4'b1010, 4'b0100, 4'b1000, 4'b0101};
        chk("pin_a_count", got[0].size(), off + 4);
        if (got[0].size() == off + 4)
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("pin_a_data%0d", j), got[0][off + j], ea[j]);
                chk($sformatf("pin_a_mk%0d", j), int'(gmk[0][off + j]), int'(em[j]));
            end
    endtask

    initial begin
        int         ec [3];
        logic [3:0] emc [3];
        reset_n = 0;
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid_%0d", i), int'(dvo[i]), 0);
            chk($sformatf("rst_data_%0d", i), int'(dout[i]), 0);
        end
        reset_n = 1;
        @(posedge clk); #1;

        // 4x4 ramp, continuous valid
        fill_a(); clear_logs();
        drive(0, 0, 4, 4, 1, 1, 1, 1, 0);
        settle();
        pin_a(0);

        // negative values, 2x2 single output carrying all markers
        fr[0] = -128; fr[1] = -1; fr[2] = -5; fr[3] = -2;
        drive(1, 0, 2, 2, 1, 1, 1, 1, 0);
        settle();
        chk("pin_b_count", got[1].size(), 1);
        if (got[1].size() == 1) begin
            chk("pin_b_data", got[1][0], -1);
            chk("pin_b_mk", int'(gmk[1][0]), 15);
        end

        // three interleaved channels
        fr[0] = 1; fr[1] = 20; fr[2]  = -3; fr[3]  = 4; fr[4]  = 10; fr[5]  = -7;
        fr[6] = 2; fr[7] = 30; fr[8]  = -9; fr[9]  = 0; fr[10] = 5;  fr[11] = -1;
        drive(2, 0, 2, 2, 3, 1, 1, 1, 0);
        settle();
        ec  = '{4, 30, -1};
        emc = '{4'b1010, 4'b0000, 4'b0101};
        chk("pin_c_count", got[2].size(), 3);
        if (got[2].size() == 3)
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("pin_c_data%0d", j), got[2][j], ec[j]);
                chk($sformatf("pin_c_mk%0d", j), int'(gmk[2][j]), int'(emc[j]));
            end

        // same ramp with ~50% valid gaps
        fill_a(); clear_logs();
        drive(0, 0, 4, 4, 1, 1, 1, 1, 50);
        settle();
        pin_a(0);

        // reset after row 0, rest of the frame without sof, then a clean frame
        clear_logs();
        drive(0, 0, 1, 4, 1, 1, 0, 1, 0);
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        drive(0, 1, 4, 4, 1, 0, 1, 0, 0);
        settle();
        chk("no_out_before_sof", got[0].size(), 0);
        drive(0, 0, 4, 4, 1, 1, 1, 1, 0);
        settle();
        pin_a(0);

        // 3-row frame: one output line, no eof; next frame normal
        clear_logs();
        for (int i = 0; i < 12; i++) fr[i] = 16 - i;
        drive(0, 0, 3, 4, 1, 1, 1, 1, 0);
        settle();
        chk("odd_frame_count", got[0].size(), 2);
        if (got[0].size() == 2) begin
            chk("odd_frame_d0", got[0][0], 16);
            chk("odd_frame_d1", got[0][1], 14);
            chk("odd_frame_mk0", int'(gmk[0][0]), 4'b1010);
            chk("odd_frame_mk1", int'(gmk[0][1]), 4'b0100);
        end
        fill_a();
        drive(0, 0, 4, 4, 1, 1, 1, 1, 0);
        settle();
        pin_a(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
